// File: rtl/aes_block_loader.sv
// aes_block_loader: pulls FIFO bytes into 128-bit AES blocks, adds PKCS#7 padding, hands blocks to the core
module aes_block_loader #(
  parameter int NUMBITS  = 8,
  parameter int BLKBYTES = 16,
  parameter int CNTBITS  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fifo_empty,
  input  logic [NUMBITS-1:0]            fifo_r_data,
  output logic                          fifo_r_enable,
  input  logic                          pkt_end,
  output logic                          pkt_busy,
  output logic [BLKBYTES*NUMBITS-1:0]   blk_data,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic                          blk_last,
  output logic [7:0]                    blk_idx,
  output logic                          err
);
  typedef enum logic [1:0] {IDLE, FILL, PAD, PRESENT} state_t;
  state_t state;
  logic [CNTBITS-1:0] byte_cnt;
  logic pend;
  logic [NUMBITS-1:0] pad_val;
  assign fifo_r_enable = (state == FILL) && !fifo_empty;
  assign blk_valid = (state == PRESENT);
  assign pkt_busy = pend;
  assign pad_val = NUMBITS'(BLKBYTES) - NUMBITS'(byte_cnt);
  // block assembly FSM with packet-end tracking; byte 0 lands in the top lane
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      pend     <= 1'b0;
      blk_data <= '0;
      blk_last <= 1'b0;
      blk_idx  <= '0;
      err      <= 1'b0;
    end else begin
      if (pkt_end && pend) err <= 1'b1;
      if (pkt_end && !pend) pend <= 1'b1;
      else if (state == PRESENT && blk_ready && blk_last) pend <= 1'b0;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          blk_idx  <= '0;
          blk_last <= 1'b0;
          state    <= !fifo_empty ? FILL : pend ? PAD : IDLE;
        end
        FILL: begin
          if (!fifo_empty) begin
            for (int i = 0; i < BLKBYTES; i++)
              if (byte_cnt == CNTBITS'(i)) blk_data[(BLKBYTES-1-i)*NUMBITS +: NUMBITS] <= fifo_r_data;
            byte_cnt <= byte_cnt + CNTBITS'(1);
            if (byte_cnt == CNTBITS'(BLKBYTES-1)) begin
              state    <= PRESENT;
              blk_last <= 1'b0;
            end
          end else if (pend) state <= PAD;
        end
        PAD: begin
          for (int i = 0; i < BLKBYTES; i++)
            if (CNTBITS'(i) >= byte_cnt) blk_data[(BLKBYTES-1-i)*NUMBITS +: NUMBITS] <= pad_val;
          state    <= PRESENT;
          blk_last <= 1'b1;
        end
        PRESENT: begin
          if (blk_ready) begin
            state <= blk_last ? IDLE : FILL;
            if (!blk_last) begin
              byte_cnt <= '0;
              blk_idx  <= blk_idx + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Read-side controller for the byte-wide packet FIFO.
- Pulls plaintext bytes from the FIFO and assembles them into 128-bit AES blocks.
- Applies PKCS#7 padding at end of packet.
- Presents each block to the AES core over a valid/ready handshake and marks the final block of every packet.

Parameters:
NUMBITS, 8, FIFO word width in bits (must stay 8).
BLKBYTES, 16, bytes per AES block.
CNTBITS, 5, byte-counter width (holds 0..BLKBYTES).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
fifo_empty  in  1  FIFO empty flag.
fifo_r_data  in  NUMBITS  FIFO head word (first-word-fall-through).
fifo_r_enable  out  1  FIFO pop strobe.
pkt_end  in  1  one-cycle pulse: final byte of current packet is visible in FIFO.
pkt_busy  out  1  packet end latched, padding/last block outstanding.
blk_data  out  BLKBYTES*NUMBITS  assembled block; byte 0 in [127:120].
blk_valid  out  1  block available.
blk_ready  in  1  AES core accepts block.
blk_last  out  1  qualifies blk_valid: final (padded) block of packet.
blk_idx  out  8  index of presented block within packet, wraps 255->0.
err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; byte_cnt=0; pend=0; all outputs 0, blk_data=0. Reset mid-operation discards any partial block. FIFO contents are not touched.
- pend: set on pkt_end; cleared when a blk_last block handshakes. pkt_busy=pend.
- pkt_end arriving while pend=1: err=1, sticky until rst, pulse otherwise ignored.
- Upstream contract: no byte of the next packet is written while pkt_busy=1.
- fifo_r_enable = (state==FILL) && !fifo_empty. Combinational; never high in IDLE/PAD/PRESENT.
- IDLE:
  - !fifo_empty -> FILL.
  - pend && fifo_empty -> PAD with byte_cnt=0.
  - Also clears blk_idx.
- FILL:
  - On each pop, fifo_r_data is stored in byte lane byte_cnt; byte_cnt++.
  - Pop with byte_cnt==15 -> PRESENT, blk_last=0.
  - No pop && pend && fifo_empty -> PAD.
  - No pop && !pend: wait in FILL indefinitely; never pad without pkt_end.
- PAD (one cycle):
  - Lanes byte_cnt..15 are written with value (16-byte_cnt), e.g. byte_cnt=0 gives sixteen 0x10 bytes.
  - Then -> PRESENT with blk_last=1.
- PRESENT:
  - blk_valid=1; blk_data, blk_last and blk_idx are held stable until handshake.
  - On blk_ready: blk_last=1 -> IDLE, pend=0; else -> FILL, byte_cnt=0, blk_idx++.
  - blk_valid is not dropped without a handshake.
- Latency:
  - Contiguous FIFO data: first pop at cycle t gives blk_valid at t+16.
  - Padded block: blk_valid 2 cycles after the last pop (FILL detect, PAD, PRESENT).
- Full packet multiple of 16 bytes: the final data block has blk_last=0, followed by a separate full pad block (0x10 x16) with blk_last=1.
- pkt_end coincident with a pop in FILL: pend is set and the byte is stored; padding is decided in a later cycle.
- blk_ready when blk_valid=0: ignored.

Test Plan:
1. Bytes 0x00..0x0F, then pkt_end; blk_ready=1 -> block0 = 0x000102..0F with blk_last=0, blk_idx=0; then block1 = 0x10 x16 with blk_last=1, blk_idx=1; pkt_busy falls after block1 handshake.
2. Bytes 0xA1..0xA5, then pkt_end -> single block A1A2A3A4A5 followed by 0x0B x11, blk_last=1, blk_valid 2 cycles after the 5th pop.
3. pkt_end with FIFO empty in IDLE (zero-length packet) -> one block of 0x10 x16, blk_last=1, no fifo_r_enable pulses.
4. Full block presented with blk_ready=0 for 10 cycles while FIFO holds 8 bytes -> blk_valid held, blk_data unchanged, fifo_r_enable=0 throughout; the 8 bytes appear in the next block after handshake.
5. fifo_empty toggles every other cycle mid-block without pkt_end -> bytes pack contiguously with no gaps or padding; blk_valid only after 16 pops.
6. rst pulse after 7 pops -> next cycle state IDLE, outputs 0. Separately, a second pkt_end while pkt_busy=1 -> err=1, remaining until rst.
